// File: rtl/periph_req_sched.sv
// Round-robin scheduler that shares one in-order peripheral slave among NB_REQ
// requesters, limits outstanding transactions and steers responses back by grant order.
module periph_req_sched #(
  parameter int unsigned NB_REQ          = 9,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IDW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_REQ-1:0]              req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]   add_i,
  input  logic [NB_REQ-1:0]              wen_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NB_REQ*BE_WIDTH-1:0]     be_i,
  output logic [NB_REQ-1:0]              gnt_o,
  output logic [NB_REQ-1:0]              r_valid_o,
  output logic [DATA_WIDTH-1:0]          r_rdata_o,
  output logic                           r_opc_o,
  output logic                           req_o,
  output logic [ADDR_WIDTH-1:0]          add_o,
  output logic                           wen_o,
  output logic [DATA_WIDTH-1:0]          wdata_o,
  output logic [BE_WIDTH-1:0]            be_o,
  output logic [IDW-1:0]                 id_o,
  input  logic                           gnt_i,
  input  logic                           r_valid_i,
  input  logic [DATA_WIDTH-1:0]          r_rdata_i,
  input  logic                           r_opc_i,
  output logic [CW-1:0]                  outstanding_o,
  output logic                           spurious_rsp_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];

  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;
  logic           found;
  logic           credit;
  logic           hs;
  logic           pop;
  logic           spur;
  logic [IDW-1:0] head;

  // Round-robin pick: first active requester at or after rr_ptr, wrapping
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % NB_REQ);
      if (!found && req_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Credit, handshake and response classification
  always_comb begin
    credit = (cnt < CW'(MAX_OUTSTANDING)) && !rst_i;
    req_o  = (|req_i) && credit;
    hs     = req_o && gnt_i;
    head   = fifo_q[rd_ptr];
    pop    = r_valid_i && (cnt != '0) && !rst_i;
    spur   = r_valid_i && (cnt == '0) && !rst_i;
  end

  // Slave-side request fields muxed from the selected requester
  always_comb begin
    add_o   = add_i[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    wen_o   = wen_i[sel];
    wdata_o = wdata_i[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
    be_o    = be_i[32'(sel)*BE_WIDTH +: BE_WIDTH];
    id_o    = sel;
  end

  // One-hot grant and response steering, data broadcast
  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      gnt_o[k]     = hs && (sel == IDW'(k));
      r_valid_o[k] = pop && (head == IDW'(k));
    end
    r_rdata_o     = r_rdata_i;
    r_opc_o       = r_opc_i;
    outstanding_o = cnt;
  end

  // Arbitration pointer, outstanding count and spurious-response pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr         <= '0;
      cnt            <= '0;
      spurious_rsp_o <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr <= IDW'((32'(sel) + 32'd1) % NB_REQ);
      end
      if (hs && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !hs) begin
        cnt <= cnt - CW'(1);
      end
      spurious_rsp_o <= spur;
    end
  end

  // Grant-order index FIFO used to route in-order responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (hs) begin
        fifo_q[wr_ptr] <= sel;
        wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
      end
    end
  end

endmodule
